// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-outstanding word reads to
// instruction memory, buffers {pc, word} pairs in a small FIFO and hands them to decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t             state, state_nxt;
    logic [31:0]        pc, pc_nxt;
    logic [31:0]        req_addr, req_addr_nxt;
    logic [31:0]        inflight_pc, inflight_pc_nxt;
    logic               kill, kill_nxt;
    logic [31:0]        fifo_pc   [FIFO_DEPTH];
    logic [31:0]        fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [CNT_W-1:0]   count, count_nxt;
    logic               handshake, push, pop, has_space_nxt;
    logic [31:0]        redirect_aligned;

    assign redirect_aligned = redirect_pc & ~32'h3;
    assign handshake        = (state == REQ) && imem_req_ready;
    assign instr_valid      = (count != '0);
    // A redirect flushes the buffer, so neither push nor pop takes effect that cycle.
    assign push             = (state == WAIT) && imem_rsp_valid && !redirect_valid;
    assign pop              = instr_valid && instr_ready && !redirect_valid;
    assign count_nxt        = redirect_valid ? '0 : count + CNT_W'(push) - CNT_W'(pop);
    assign has_space_nxt    = (count_nxt < CNT_W'(FIFO_DEPTH));

    assign imem_req_valid   = (state == REQ);
    assign imem_req_addr    = imem_req_valid ? req_addr : '0;
    assign instr            = instr_valid ? fifo_data[rd_ptr] : '0;
    assign instr_pc         = instr_valid ? fifo_pc[rd_ptr]   : '0;

    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        req_addr_nxt    = req_addr;
        inflight_pc_nxt = inflight_pc;
        kill_nxt        = kill;
        case (state)
            IDLE: begin
                if (redirect_valid) begin
                    pc_nxt       = redirect_aligned;
                    req_addr_nxt = redirect_aligned;
                    state_nxt    = REQ;
                end else if (count < CNT_W'(FIFO_DEPTH)) begin
                    req_addr_nxt = pc;
                    state_nxt    = REQ;
                end
            end
            REQ: begin
                if (handshake) inflight_pc_nxt = req_addr;
                // The request cannot be withdrawn; a pending kill turns its response into a drop.
                if (redirect_valid) begin
                    pc_nxt = redirect_aligned;
                    if (handshake) begin
                        state_nxt = DROP;
                        kill_nxt  = 1'b0;
                    end else begin
                        kill_nxt  = 1'b1;
                    end
                end else if (handshake) begin
                    if (kill) begin
                        state_nxt = DROP;
                        kill_nxt  = 1'b0;
                    end else begin
                        pc_nxt    = pc + 32'd4;
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_nxt = redirect_aligned;
                    if (imem_rsp_valid) begin
                        req_addr_nxt = redirect_aligned;
                        state_nxt    = REQ;
                    end else begin
                        state_nxt    = DROP;
                    end
                end else if (imem_rsp_valid) begin
                    if (has_space_nxt) begin
                        req_addr_nxt = pc;
                        state_nxt    = REQ;
                    end else begin
                        state_nxt    = IDLE;
                    end
                end
            end
            DROP: begin
                if (redirect_valid) pc_nxt = redirect_aligned;
                if (imem_rsp_valid) begin
                    req_addr_nxt = redirect_valid ? redirect_aligned : pc;
                    state_nxt    = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            pc     <= RESET_PC & ~32'h3;
            kill   <= 1'b0;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            kill  <= kill_nxt;
            count <= count_nxt;
            if (redirect_valid) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Datapath registers carry no reset; outputs are gated by their valids instead.
    always_ff @(posedge clk) begin
        req_addr    <= req_addr_nxt;
        inflight_pc <= inflight_pc_nxt;
        if (push) begin
            fifo_pc[wr_ptr]   <= inflight_pc;
            fifo_data[wr_ptr] <= imem_rsp_data;
        end
    end

endmodule
